// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and types for the I/D memory port arbiter.
// Address/word widths match the single-port 32x64k memory.
package mem_port_arbiter_pkg;

   localparam int ADDR_W = 16;
   localparam int WORD_W = 32;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_I    = 2'd1,
      SRC_D    = 2'd2
   } src_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I requester, D requester and memory-side signals of the arbiter.
// The arbiter uses the slave view; requesters and the memory model use master.
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic  i_req;
   addr_t i_addr;
   logic  i_gnt;
   logic  i_rvalid;
   word_t i_rdata;

   logic  d_req;
   logic  d_we;
   addr_t d_addr;
   word_t d_wdata;
   logic  d_gnt;
   logic  d_rvalid;
   word_t d_rdata;

   addr_t mem_a;
   logic  mem_w;
   word_t mem_d;
   word_t mem_q;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_a, mem_w, mem_d
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_a, mem_w, mem_d
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between I-fetch and load/store: D has priority,
// a starvation counter forces an I grant, and a 2-bit tag routes the late mem_q.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt_r;
   logic [CNT_W-1:0] starve_cnt_s;
   logic             force_i_s;
   logic             i_gnt_s;
   logic             d_gnt_s;
   src_e             src_s;
   addr_t            mem_a_s;
   logic             mem_w_s;
   word_t            mem_d_s;
   logic             i_pend_r;
   logic             d_pend_r;

   // Same-cycle grant decision; nothing is issued while reset is held
   always_comb begin
      force_i_s = 1'b0;
      d_gnt_s   = 1'b0;
      i_gnt_s   = 1'b0;
      src_s     = SRC_NONE;
      if (rst) begin
         src_s = SRC_NONE;
      end else begin
         force_i_s = bus.i_req && (starve_cnt_r == STARVE_LIM);
         d_gnt_s   = bus.d_req && !force_i_s;
         i_gnt_s   = bus.i_req && !d_gnt_s;
         if (d_gnt_s) begin
            src_s = SRC_D;
         end else if (i_gnt_s) begin
            src_s = SRC_I;
         end else begin
            src_s = SRC_NONE;
         end
      end
   end

   // Memory port mux; an ungranted cycle becomes a discarded read of address 0
   always_comb begin
      mem_a_s = {ADDR_W{1'b0}};
      mem_w_s = 1'b0;
      mem_d_s = {WORD_W{1'b0}};
      case (src_s)
         SRC_D: begin
            mem_a_s = bus.d_addr;
            mem_w_s = bus.d_we;
         end
         SRC_I: begin
            mem_a_s = bus.i_addr;
         end
         default: begin
            mem_a_s = {ADDR_W{1'b0}};
         end
      endcase
      if (rst) begin
         mem_d_s = {WORD_W{1'b0}};
      end else begin
         mem_d_s = bus.d_wdata;
      end
   end

   // Starvation counter: counts consecutive I losses, saturating at the limit
   always_comb begin
      starve_cnt_s = {CNT_W{1'b0}};
      if (bus.i_req && !i_gnt_s) begin
         if (starve_cnt_r < STARVE_LIM) begin
            starve_cnt_s = starve_cnt_r + 8'd1;
         end else begin
            starve_cnt_s = starve_cnt_r;
         end
      end else begin
         starve_cnt_s = {CNT_W{1'b0}};
      end
   end

   // Counter and read-return tag; the tag flops are the rvalid outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_r <= {CNT_W{1'b0}};
         i_pend_r     <= 1'b0;
         d_pend_r     <= 1'b0;
      end else begin
         starve_cnt_r <= starve_cnt_s;
         i_pend_r     <= i_gnt_s;
         d_pend_r     <= d_gnt_s && !bus.d_we;
      end
   end

   assign bus.i_gnt    = i_gnt_s;
   assign bus.d_gnt    = d_gnt_s;
   assign bus.mem_a    = mem_a_s;
   assign bus.mem_w    = mem_w_s;
   assign bus.mem_d    = mem_d_s;
   assign bus.i_rvalid = i_pend_r;
   assign bus.d_rvalid = d_pend_r;
   assign bus.i_rdata  = bus.mem_q;
   assign bus.d_rdata  = bus.mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_MAX=3) with a registered-Q
// single-port memory model that holds Q during writes.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   typedef struct {
      logic        i_req;
      logic [15:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [15:0] d_addr;
      logic [31:0] d_wdata;
      logic        e_i_gnt;
      logic        e_d_gnt;
      logic        e_mem_w;
      logic [15:0] e_mem_a;
      logic        e_i_rv;
      logic        e_d_rv;
      logic [31:0] e_rdata;
   } vec_t;

   localparam logic [31:0] DAT10 = 32'hDEADBEEF;
   localparam logic [31:0] DAT30 = 32'hA5A50030;
   localparam logic [31:0] DAT40 = 32'h0BAD0040;
   localparam logic [31:0] DAT20 = 32'h12345678;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   logic [31:0] mem [0:65535];
   logic [31:0] mem_q_r = 32'd0;
   logic        pre_we = 1'b0;
   logic [15:0] pre_a = 16'd0;
   logic [31:0] pre_d = 32'd0;

   vec_t vecs [20];

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_MAX(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model: registered Q, Q held on write cycles, bench preload port
   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_a] <= pre_d;
      end else if (bus.mem_w) begin
         mem[bus.mem_a] <= bus.mem_d;
      end else begin
         mem_q_r <= mem[bus.mem_a];
      end
   end
   assign bus.mem_q = mem_q_r;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1;
      pre_a  = a;
      pre_d  = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                        input logic dw, input logic [15:0] da, input logic [31:0] dd);
      bus.i_req   = ir;
      bus.i_addr  = ia;
      bus.d_req   = dr;
      bus.d_we    = dw;
      bus.d_addr  = da;
      bus.d_wdata = dd;
   endtask

   function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr,
                               input logic dw, input logic [15:0] da, input logic [31:0] dd,
                               input logic eig, input logic edg, input logic emw,
                               input logic [15:0] ema, input logic eirv, input logic edrv,
                               input logic [31:0] erd);
      vec_t v;
      v.i_req = ir;  v.i_addr = ia;  v.d_req = dr;  v.d_we = dw;
      v.d_addr = da; v.d_wdata = dd; v.e_i_gnt = eig; v.e_d_gnt = edg;
      v.e_mem_w = emw; v.e_mem_a = ema; v.e_i_rv = eirv; v.e_d_rv = edrv;
      v.e_rdata = erd;
      return v;
   endfunction

   initial begin
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0);

      // I read, then idle with return
      vecs[0]  = mk(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 32'h0);
      vecs[1]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, DAT10);
      // D write then D read back
      vecs[2]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, DAT20, 1'b0, 1'b1, 1'b1, 16'h0020, 1'b0, 1'b0, 32'h0);
      vecs[3]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 32'h0);
      vecs[4]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, DAT20);
      // Ten cycles of contention: D,D,D,I,D,D,D,I,D,D
      for (int k = 0; k < 10; k++) begin
         logic gi;
         logic pi;
         gi = ((k % 4) == 3);
         pi = (k > 0) && (((k - 1) % 4) == 3);
         vecs[5 + k] = mk(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0030, 32'h0,
                          gi, !gi, 1'b0, gi ? 16'h0010 : 16'h0030,
                          pi, (k > 0) && !pi, (k == 0) ? 32'h0 : (pi ? DAT10 : DAT30));
      end
      // I read at N, D read at N+1; then D read followed by a write
      vecs[15] = mk(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b1, DAT30);
      vecs[16] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, DAT10);
      vecs[17] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b1, DAT40);
      vecs[18] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0050, 32'h55, 1'b0, 1'b1, 1'b1, 16'h0050, 1'b0, 1'b1, DAT20);
      vecs[19] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0);

      preload(16'h0010, DAT10);
      preload(16'h0030, DAT30);
      preload(16'h0040, DAT40);

      // Reset held with both requesting: nothing issued
      drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0040, 32'hFFFF0000);
      @(negedge clk);
      chk("rst.i_gnt", 32'(bus.i_gnt), 32'd0);
      chk("rst.d_gnt", 32'(bus.d_gnt), 32'd0);
      chk("rst.mem_w", 32'(bus.mem_w), 32'd0);
      chk("rst.mem_a", 32'(bus.mem_a), 32'd0);
      chk("rst.mem_d", bus.mem_d, 32'd0);
      chk("rst.i_rv", 32'(bus.i_rvalid), 32'd0);
      chk("rst.d_rv", 32'(bus.d_rvalid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rel.d_gnt", 32'(bus.d_gnt), 32'd1);
      chk("rel.i_gnt", 32'(bus.i_gnt), 32'd0);
      chk("rel.mem_a", 32'(bus.mem_a), 32'h40);
      @(posedge clk); #1;
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0);
      @(negedge clk);
      chk("rel.d_rv", 32'(bus.d_rvalid), 32'd1);
      chk("rel.d_rdata", bus.d_rdata, DAT40);

      for (int r = 0; r < 20; r++) begin
         @(posedge clk); #1;
         drive(vecs[r].i_req, vecs[r].i_addr, vecs[r].d_req, vecs[r].d_we, vecs[r].d_addr, vecs[r].d_wdata);
         @(negedge clk);
         chk($sformatf("vec%0d.i_gnt", r), 32'(bus.i_gnt), 32'(vecs[r].e_i_gnt));
         chk($sformatf("vec%0d.d_gnt", r), 32'(bus.d_gnt), 32'(vecs[r].e_d_gnt));
         chk($sformatf("vec%0d.mem_w", r), 32'(bus.mem_w), 32'(vecs[r].e_mem_w));
         chk($sformatf("vec%0d.mem_a", r), 32'(bus.mem_a), 32'(vecs[r].e_mem_a));
         chk($sformatf("vec%0d.i_rv", r), 32'(bus.i_rvalid), 32'(vecs[r].e_i_rv));
         chk($sformatf("vec%0d.d_rv", r), 32'(bus.d_rvalid), 32'(vecs[r].e_d_rv));
         if (vecs[r].e_i_rv) chk($sformatf("vec%0d.i_rdata", r), bus.i_rdata, vecs[r].e_rdata);
         if (vecs[r].e_d_rv) chk($sformatf("vec%0d.d_rdata", r), bus.d_rdata, vecs[r].e_rdata);
      end

      // Async reset right after an I grant kills the return and the counter
      @(posedge clk); #1;
      drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0);
      @(negedge clk);
      chk("mid.i_gnt", 32'(bus.i_gnt), 32'd1);
      @(posedge clk); #1;
      drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0030, 32'h0);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid.i_rv", 32'(bus.i_rvalid), 32'd0);
      chk("mid.gnts", {30'd0, bus.i_gnt, bus.d_gnt}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         @(negedge clk);
         chk($sformatf("post%0d.d_gnt", k), 32'(bus.d_gnt), (k < 3) ? 32'd1 : 32'd0);
         chk($sformatf("post%0d.i_gnt", k), 32'(bus.i_gnt), (k < 3) ? 32'd0 : 32'd1);
         if (k == 0) chk("post0.i_rv", 32'(bus.i_rvalid), 32'd0);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("sat%0d.d_gnt", k), 32'(bus.d_gnt), 32'd1);
      end
      // Counter now at limit; a reset pulse must return priority to D
      @(posedge clk); #1;
      rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      chk("satrst.d_gnt", 32'(bus.d_gnt), 32'd1);
      chk("satrst.i_gnt", 32'(bus.i_gnt), 32'd0);
      chk("satrst.d_rv", 32'(bus.d_rvalid), 32'd0);

      @(posedge clk); #1;
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0);
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
